// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS main controller: Moore FSM with datapath strobes, ALU decoder
// and a retired-instruction counter.
module mips_multicycle_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       PCSrc,
  output logic             PCEn,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] RetiredCount
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] ADDIEXEC = 4'd9;
  localparam logic [3:0] ADDIWB   = 4'd10;
  localparam logic [3:0] JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] state, next_state;
  logic       funct_legal;
  logic [2:0] funct_alu;
  logic       retire;

  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = 3'b010;
    case (Funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEXEC;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (Op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = MEMWB;
      EXECUTE:  next_state = funct_legal ? ALUWB : FETCH;
      ADDIEXEC: next_state = ADDIWB;
      default:  next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  assign retire = (state == MEMWB) || (state == MEMWRITE) || (state == ALUWB) ||
                  (state == ADDIWB) || (state == BRANCH) || (state == JUMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       RetiredCount <= '0;
    else if (retire) RetiredCount <= RetiredCount + CNT_W'(1);
  end

  assign State = state;

  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    PCSrc      = 2'b00;
    PCEn       = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB    = 2'b01;
        ALUControl = 3'b010;
        IRWrite    = 1'b1;
        PCEn       = 1'b1;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        ALUControl = 3'b010;
      end
      MEMADR, ADDIEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = 3'b010;
      end
      MEMREAD:  IorD = 1'b1;
      MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      ADDIWB:   RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b110;
        PCSrc      = 2'b01;
        PCEn       = Zero;
      end
      JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
    // State is already FETCH during reset, so only the write strobes need gating.
    if (reset) begin
      IRWrite  = 1'b0;
      PCEn     = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Main control unit for the multicycle MIPS datapath.
- A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback.
- It drives the datapath mux selects and write enables, and its internal ALU decoder generates the 3-bit ALUControl that the ALU consumes every cycle.
- It also keeps a retired-instruction counter for debug and verification.

Parameters:
CNT_W  32  width of the retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; forces state to FETCH and clears counter
Op  input  6  instruction bits [31:26] from the instruction register
Funct  input  6  instruction bits [5:0] from the instruction register
Zero  input  1  ALU zero flag, same cycle as the ALU result
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register load enable
RegDst  output  1  write register select: 0 = rt, 1 = rd
MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = memory data
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU operand A select: 0 = PC, 1 = register A
ALUSrcB  output  2  ALU operand B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
ALUControl  output  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
PCSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
PCEn  output  1  PC load enable
State  output  4  current state encoding, for debug
RetiredCount  output  CNT_W  number of completed instructions

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
- Codes 12-15 are unreachable. If entered, the FSM returns to FETCH on the next edge with no strobes.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by Op:
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000000 (R-type) -> EXECUTE.
    - 000100 (beq) -> BRANCH.
    - 001000 (addi) -> ADDIEXEC.
    - 000010 (j) -> JUMP.
    - Any other Op -> FETCH; illegal instruction, no writes, not counted.
  - MEMADR -> MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTE -> ALUWB if Funct is legal, otherwise FETCH with no register write.
  - ALUWB -> FETCH.
  - ADDIEXEC -> ADDIWB -> FETCH.
  - BRANCH -> FETCH.
  - JUMP -> FETCH.
- Op and Funct are sampled only in DECODE, MEMADR and EXECUTE.
- Outputs are Moore-decoded from state. Any output not listed for a state is 0.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, IRWrite=1, PCEn=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target into ALUOut).
  - MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl=010.
  - MEMREAD: IorD=1.
  - MEMWRITE: IorD=1, MemWrite=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct:
    - 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111.
    - Any other Funct -> 010.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, PCEn=Zero. This is the only Mealy term.
  - JUMP: PCSrc=10, PCEn=1.
- Reset:
  - While reset is high, State=FETCH and RetiredCount=0.
  - While reset is high, IRWrite, PCEn, RegWrite and MemWrite are forced to 0. Mux selects and ALUControl take their FETCH values.
  - Reset asserted mid-instruction aborts the instruction immediately. The instruction is not counted.
  - First fetch occurs on the first rising edge after reset deasserts.
- RetiredCount:
  - Increments by 1 on the edge leaving MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH or JUMP.
  - A not-taken beq is also counted.
  - Illegal Op or illegal Funct is not counted.
  - Wraps modulo 2^CNT_W with no flag.
- Latency in cycles, counting FETCH: lw 5; sw, R-type and addi 4; beq and j 3; illegal Op 2; illegal Funct 3.

Test Plan:
- Reset mid-MEMREAD, with reset high for 1 cycle -> State=0 immediately; IRWrite=PCEn=RegWrite=MemWrite=0 while high; RetiredCount=0; first post-reset edge moves State to 1.
- lw (Op=100011) -> States 0,1,2,3,4,0; MemWrite never 1; RegWrite=1 with MemtoReg=1 only in state 4; RetiredCount 0 -> 1.
- R-type with each Funct 100000, 100010, 100100, 100101, 101010 -> ALUControl in EXECUTE is 010, 110, 000, 001, 111 respectively; state 7 asserts RegDst=1, RegWrite=1. Funct=000000 -> 0,1,6,0 with no RegWrite and no count.
- beq with Zero=1 -> PCEn=1 and PCSrc=01 in state 8. Zero=0 -> PCEn=0. Both cases increment RetiredCount.
- sw, addi and j back to back -> sequences 0,1,2,5 / 0,1,9,10 / 0,1,11; MemWrite only in state 5; PCSrc=10 with PCEn=1 in state 11; RetiredCount=3.
- CNT_W=4, 16 j instructions -> RetiredCount wraps 15 -> 0. Op=111111 -> 0,1,0 with no strobes besides FETCH's.
